// File: rtl/p_out_stage.sv
// P output stage of the DSP slice: P/carry register, pattern detector,
// overflow/underflow flags and optional pattern-driven auto-reset of P.
module p_out_stage #(
  parameter int WIDTH            = 48,
  parameter int PREG             = 1,
  parameter int AUTORESET_PATDET = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rstp,
  input  logic             cep,
  input  logic [WIDTH-1:0] alu_p,
  input  logic             alu_carryout,
  input  logic             carry_valid,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] p,
  output logic             carryout,
  output logic             patterndetect,
  output logic             patternbdetect,
  output logic             overflow,
  output logic             underflow
);

  logic pd_c;
  logic pbd_c;
  logic cy_c;

  // Masked bits count as matching for both the pattern and its complement.
  assign pd_c  = &(~(alu_p ^ pattern) | mask);
  assign pbd_c = &((alu_p ^ pattern) | mask);
  assign cy_c  = carry_valid ? alu_carryout : 1'b0;

  generate
    if (PREG == 1) begin : g_preg
      logic [WIDTH-1:0] p_r;
      logic             cy_r;
      logic             pd_r;
      logic             pbd_r;
      logic             pd_past;
      logic             pbd_past;
      logic             auto_rst;

      // Auto-reset looks only at registered detector state, never at the ALU.
      always_comb begin
        auto_rst = 1'b0;
        if (AUTORESET_PATDET == 1) begin
          auto_rst = pd_r;
        end else if (AUTORESET_PATDET == 2) begin
          auto_rst = pd_past & ~pd_r;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_r      <= '0;
          cy_r     <= 1'b0;
          pd_r     <= 1'b0;
          pbd_r    <= 1'b0;
          pd_past  <= 1'b0;
          pbd_past <= 1'b0;
        end else if (rstp) begin
          p_r      <= '0;
          cy_r     <= 1'b0;
          pd_r     <= 1'b0;
          pbd_r    <= 1'b0;
          pd_past  <= 1'b0;
          pbd_past <= 1'b0;
        end else if (cep) begin
          pd_past  <= pd_r;
          pbd_past <= pbd_r;
          if (auto_rst) begin
            p_r   <= '0;
            cy_r  <= 1'b0;
            pd_r  <= 1'b0;
            pbd_r <= 1'b0;
          end else begin
            p_r   <= alu_p;
            cy_r  <= cy_c;
            pd_r  <= pd_c;
            pbd_r <= pbd_c;
          end
        end
      end

      assign p              = p_r;
      assign carryout       = cy_r;
      assign patterndetect  = pd_r;
      assign patternbdetect = pbd_r;
      // A detect that was true last cycle and is now lost on both sides.
      assign overflow       = pd_past & ~pd_r & ~pbd_r;
      assign underflow      = pbd_past & ~pd_r & ~pbd_r;
    end else begin : g_comb
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, rstp, cep};

      assign p              = alu_p;
      assign carryout       = cy_c;
      assign patterndetect  = pd_c;
      assign patternbdetect = pbd_c;
      assign overflow       = 1'b0;
      assign underflow      = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_p_out_stage.sv
// Directed bench for p_out_stage: registered, combinational, reset-on-match
// and reset-on-lost-match instances driven from one linear sequence.
module tb_p_out_stage;

  localparam int W = 48;

  logic         clk;
  logic         rst_n;
  logic         rstp;
  logic         cep;
  logic [W-1:0] alu_p;
  logic         alu_carryout;
  logic         carry_valid;
  logic [W-1:0] pattern;
  logic [W-1:0] mask;

  logic [W-1:0] r_p, c_p, ar_p, nm_p;
  logic         r_co, r_pd, r_pbd, r_ovf, r_unf;
  logic         c_co, c_pd, c_pbd, c_ovf, c_unf;
  logic         ar_co, ar_pd, ar_pbd, ar_ovf, ar_unf;
  logic         nm_co, nm_pd, nm_pbd, nm_ovf, nm_unf;

  logic         ctr_rstp;
  logic         ar_cep;
  logic         nm_cep;
  logic [W-1:0] ar_alu_p;
  logic [W-1:0] nm_alu_p;
  logic [W-1:0] ar_pattern;
  logic [W-1:0] nm_pattern;
  logic [W-1:0] zero_mask;

  int compared;
  int mismatched;

  // The auto-reset instances count by feeding P+1 back as the ALU result.
  assign ar_alu_p   = ar_p + 48'd1;
  assign nm_alu_p   = nm_p + 48'd1;
  assign ar_pattern = 48'h64;
  assign nm_pattern = 48'h3;
  assign zero_mask  = '0;

  p_out_stage #(.WIDTH(W), .PREG(1), .AUTORESET_PATDET(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .rstp(rstp), .cep(cep), .alu_p(alu_p),
    .alu_carryout(alu_carryout), .carry_valid(carry_valid),
    .pattern(pattern), .mask(mask), .p(r_p), .carryout(r_co),
    .patterndetect(r_pd), .patternbdetect(r_pbd),
    .overflow(r_ovf), .underflow(r_unf)
  );

  p_out_stage #(.WIDTH(W), .PREG(0), .AUTORESET_PATDET(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .rstp(rstp), .cep(cep), .alu_p(alu_p),
    .alu_carryout(alu_carryout), .carry_valid(carry_valid),
    .pattern(pattern), .mask(mask), .p(c_p), .carryout(c_co),
    .patterndetect(c_pd), .patternbdetect(c_pbd),
    .overflow(c_ovf), .underflow(c_unf)
  );

  p_out_stage #(.WIDTH(W), .PREG(1), .AUTORESET_PATDET(1)) u_ar (
    .clk(clk), .rst_n(rst_n), .rstp(ctr_rstp), .cep(ar_cep), .alu_p(ar_alu_p),
    .alu_carryout(1'b0), .carry_valid(1'b0),
    .pattern(ar_pattern), .mask(zero_mask), .p(ar_p), .carryout(ar_co),
    .patterndetect(ar_pd), .patternbdetect(ar_pbd),
    .overflow(ar_ovf), .underflow(ar_unf)
  );

  p_out_stage #(.WIDTH(W), .PREG(1), .AUTORESET_PATDET(2)) u_nm (
    .clk(clk), .rst_n(rst_n), .rstp(ctr_rstp), .cep(nm_cep), .alu_p(nm_alu_p),
    .alu_carryout(1'b0), .carry_valid(1'b0),
    .pattern(nm_pattern), .mask(zero_mask), .p(nm_p), .carryout(nm_co),
    .patterndetect(nm_pd), .patternbdetect(nm_pbd),
    .overflow(nm_ovf), .underflow(nm_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] pat,
                               input logic [W-1:0] msk, input logic cv,
                               input logic co);
    alu_p        = a;
    pattern      = pat;
    mask         = msk;
    carry_valid  = cv;
    alu_carryout = co;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b1;
    rstp       = 1'b0;
    cep        = 1'b1;
    ctr_rstp   = 1'b0;
    ar_cep     = 1'b0;
    nm_cep     = 1'b0;
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h0, 48'h0, 1'b0, 1'b0);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_p", r_p, 48'h0);
    checkOutput("rst_co", 48'(r_co), 48'h0);
    checkOutput("rst_pd", 48'(r_pd), 48'h0);
    checkOutput("rst_pbd", 48'(r_pbd), 48'h0);
    checkOutput("rst_ovf", 48'(r_ovf), 48'h0);
    checkOutput("rst_unf", 48'(r_unf), 48'h0);
    checkOutput("rst_ar_p", ar_p, 48'h0);
    #3 rst_n = 1'b1;

    tick();
    checkOutput("cap_p", r_p, 48'hFFFF_FFFF_FFFF);
    checkOutput("cap_pbd", 48'(r_pbd), 48'h1);
    checkOutput("cap_pd", 48'(r_pd), 48'h0);

    applyStimulus(48'h5, 48'h0, 48'h0, 1'b0, 1'b0);
    tick();
    checkOutput("load5_p", r_p, 48'h5);
    cep = 1'b0;
    applyStimulus(48'h9, 48'h0, 48'h0, 1'b0, 1'b0);
    tick();
    checkOutput("hold_p", r_p, 48'h5);
    rstp = 1'b1;
    tick();
    checkOutput("rstp_p", r_p, 48'h0);
    rstp = 1'b0;
    cep  = 1'b1;

    applyStimulus(48'h0000_7FFF_FFFF, 48'h0, 48'h0000_7FFF_FFFF, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_pd1", 48'(r_pd), 48'h1);
    checkOutput("ovf_pre", 48'(r_ovf), 48'h0);
    applyStimulus(48'h0000_8000_0000, 48'h0, 48'h0000_7FFF_FFFF, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_pd0", 48'(r_pd), 48'h0);
    checkOutput("ovf_set", 48'(r_ovf), 48'h1);
    checkOutput("ovf_unf", 48'(r_unf), 48'h0);
    tick();
    checkOutput("ovf_pulse", 48'(r_ovf), 48'h0);

    applyStimulus(48'hFFFF_8000_0000, 48'h0, 48'h0000_7FFF_FFFF, 1'b0, 1'b0);
    tick();
    checkOutput("unf_pbd1", 48'(r_pbd), 48'h1);
    checkOutput("unf_pre", 48'(r_unf), 48'h0);
    applyStimulus(48'hFFFF_7FFF_FFFF, 48'h0, 48'h0000_7FFF_FFFF, 1'b0, 1'b0);
    tick();
    checkOutput("unf_pbd0", 48'(r_pbd), 48'h0);
    checkOutput("unf_set", 48'(r_unf), 48'h1);
    checkOutput("unf_ovf", 48'(r_ovf), 48'h0);

    applyStimulus(48'h1234_5678_9ABC, 48'h0, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    tick();
    applyStimulus(48'h0000_0000_0001, 48'h0, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    tick();
    checkOutput("allmask_pd", 48'(r_pd), 48'h1);
    checkOutput("allmask_pbd", 48'(r_pbd), 48'h1);
    checkOutput("allmask_ovf", 48'(r_ovf), 48'h0);
    checkOutput("allmask_unf", 48'(r_unf), 48'h0);

    // Asynchronous reset mid-run must leave no stale past to raise a flag.
    applyStimulus(48'h0000_7FFF_FFFF, 48'h0, 48'h0000_7FFF_FFFF, 1'b0, 1'b0);
    tick();
    checkOutput("mid_pd1", 48'(r_pd), 48'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_pd", 48'(r_pd), 48'h0);
    rst_n = 1'b1;
    applyStimulus(48'h0000_8000_0000, 48'h0, 48'h0000_7FFF_FFFF, 1'b0, 1'b0);
    tick();
    checkOutput("mid_p", r_p, 48'h0000_8000_0000);
    checkOutput("mid_ovf", 48'(r_ovf), 48'h0);

    applyStimulus(48'h0, 48'h0, 48'h0, 1'b0, 1'b1);
    tick();
    checkOutput("cy_logic", 48'(r_co), 48'h0);
    applyStimulus(48'h0, 48'h0, 48'h0, 1'b1, 1'b1);
    #1;
    checkOutput("cy_comb", 48'(c_co), 48'h1);
    tick();
    checkOutput("cy_arith", 48'(r_co), 48'h1);

    applyStimulus(48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 48'h0, 1'b0, 1'b1);
    #1;
    checkOutput("comb_p", c_p, 48'h1234_5678_9ABC);
    checkOutput("comb_pd", 48'(c_pd), 48'h1);
    checkOutput("comb_pbd", 48'(c_pbd), 48'h0);
    checkOutput("comb_co", 48'(c_co), 48'h0);
    applyStimulus(48'h1234_5678_9ABC, 48'hEDCB_A987_6543, 48'h0, 1'b0, 1'b0);
    #1;
    checkOutput("comb_pbd1", 48'(c_pbd), 48'h1);
    checkOutput("comb_pd0", 48'(c_pd), 48'h0);
    applyStimulus(48'h0000_8000_0000, 48'h0, 48'h0000_7FFF_FFFF, 1'b0, 1'b0);
    #1;
    checkOutput("comb_ovf", 48'(c_ovf), 48'h0);

    // Reset-on-lost-match: counts 1,2,3 (match), 4, then clears.
    nm_cep = 1'b1;
    repeat (3) tick();
    checkOutput("nm_p3", nm_p, 48'h3);
    checkOutput("nm_pd3", 48'(nm_pd), 48'h1);
    tick();
    checkOutput("nm_p4", nm_p, 48'h4);
    checkOutput("nm_ovf", 48'(nm_ovf), 48'h1);
    tick();
    checkOutput("nm_clr", nm_p, 48'h0);
    tick();
    checkOutput("nm_restart", nm_p, 48'h1);
    nm_cep = 1'b0;

    // Reset-on-match counter wraps at 0x64.
    ar_cep = 1'b1;
    repeat (100) tick();
    checkOutput("ar_p64", ar_p, 48'h64);
    checkOutput("ar_pd64", 48'(ar_pd), 48'h1);
    tick();
    checkOutput("ar_clr", ar_p, 48'h0);
    checkOutput("ar_clr_ovf", 48'(ar_ovf), 48'h1);
    tick();
    checkOutput("ar_restart", ar_p, 48'h1);
    repeat (99) tick();
    checkOutput("ar_p64b", ar_p, 48'h64);
    ctr_rstp = 1'b1;
    tick();
    ctr_rstp = 1'b0;
    checkOutput("ar_rstp_p", ar_p, 48'h0);
    checkOutput("ar_rstp_ovf", 48'(ar_ovf), 48'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
